regbus_master: RTL and testbench
================================

REGBUS_MASTER -- requirements
Module: regbus_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, register-window base; bits [5:0] ignored.
REQ-002 clk  input  1  master clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  CPU accepts response.
REQ-013 rsp_rdata  output  32  load result, aligned/extended; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected, no bus access made.
REQ-015 addr  output  4  register word offset [5:2] to register file.
REQ-016 wben  output  4  byte-lane write enables.
REQ-017 r_wn  output  1  1 = read/idle, 0 = write this cycle.
REQ-018 wdata  output  32  lane-replicated write data.
REQ-019 rdata  input  32  combinational read data from register file.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid&req_ready latch all req_* fields and evaluate errors; error -> RESP, else -> ACCESS.
REQ-022 Error SHALL be flagged for: req_size=11; misalignment (half with addr[0]=1, word with addr[1:0]!=0); req_addr[31:6]!=BASE_ADDR[31:6]; offset 4'hD-4'hF; store to read-only offsets 4'h0, 4'h1, 4'h3, 4'hB, 4'hC.
REQ-023 ACCESS lasts exactly one cycle; addr=latched [5:2]; store drives r_wn=0 with wben/wdata for that cycle only; load drives r_wn=1, wben=0 and captures rdata at the closing edge.
REQ-024 wben: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-025 wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-026 Load extract: rdata>>(8*addr[1:0]), then 8/16/32-bit zero- or sign-extension per req_signed.
REQ-027 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&rsp_ready, then -> IDLE; rsp_ready held low stalls indefinitely.
REQ-028 Latency: request accepted at edge N, bus cycle N..N+1, rsp_valid high from edge N+1 (error: from edge N); peak rate one request per 3 cycles (error: 2).
REQ-029 Outside ACCESS: r_wn=1, wben=0, addr=0, wdata=0; at most one write strobe per request.
REQ-030 req_valid while not in IDLE SHALL be ignored (no latch); req_* fields may change freely after acceptance.

Reset
REQ-031 reset low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, r_wn=1, wben=0, addr=0, wdata=0.
REQ-032 Reset asserted during ACCESS SHALL abort the request with no write strobe after reset assertion and no response.

Structure
REQ-033 Package regbus_pkg holds: size encodings, FSM state enum, register offset constants (0x0-0xC), read-only offset list, default BASE_ADDR.
REQ-034 One sub-module regbus_lane_align: combinational wben/wdata generation and load extract/extend; FSM and latches stay in regbus_master.

Verification
REQ-035 Word store 0xDEADBEEF to 0x4000_0018 -> one cycle addr=4'h6, wben=4'b1111, r_wn=0, wdata=0xDEADBEEF; then rsp_valid, rsp_err=0.
REQ-036 Signed byte load 0x4000_0003 with rdata=0x8000_0000 -> addr=4'h0, rsp_rdata=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-037 Half store 0xA5C3 to 0x4000_0016 -> wben=4'b1100, wdata=0xA5C3_A5C3; half load 0x4000_0011 -> rsp_err=1, r_wn stays 1.
REQ-038 Store to 0x4000_0000, load from 0x4000_0034, load from 0x5000_0000, size=11 -> each rsp_err=1, rsp_rdata=0, no bus cycle.
REQ-039 rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored; back-to-back requests -> 3-cycle spacing.
REQ-040 reset low during ACCESS of store -> r_wn=1 asynchronously, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus master: access sizes,
// FSM states, register offset map and the read-only subset of that map.
package regbus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Register word offsets within the 64-byte window.
  localparam logic [3:0] OFF_ID      = 4'h0;
  localparam logic [3:0] OFF_VERSION = 4'h1;
  localparam logic [3:0] OFF_CTRL    = 4'h2;
  localparam logic [3:0] OFF_STATUS  = 4'h3;
  localparam logic [3:0] OFF_IRQ_EN  = 4'h4;
  localparam logic [3:0] OFF_IRQ_CLR = 4'h5;
  localparam logic [3:0] OFF_DATA0   = 4'h6;
  localparam logic [3:0] OFF_DATA1   = 4'h7;
  localparam logic [3:0] OFF_DATA2   = 4'h8;
  localparam logic [3:0] OFF_DATA3   = 4'h9;
  localparam logic [3:0] OFF_SCRATCH = 4'hA;
  localparam logic [3:0] OFF_CAPS    = 4'hB;
  localparam logic [3:0] OFF_TIMER   = 4'hC;

  // Highest implemented offset; D..F are holes in the map.
  localparam logic [3:0] OFF_LAST = OFF_TIMER;

  localparam int NUM_RO = 5;
  localparam logic [3:0] RO_OFFSETS [NUM_RO] =
    '{OFF_ID, OFF_VERSION, OFF_STATUS, OFF_CAPS, OFF_TIMER};

  // True when a store to this offset must be rejected.
  function automatic logic is_read_only(input logic [3:0] off);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (off == RO_OFFSETS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/regbus_lane_align.sv
// Byte-lane steering: store-side write enables and lane-replicated data,
// load-side shift-down plus zero/sign extension. Purely combinational.
module regbus_lane_align
  import regbus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wben,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  // Lane enables, replicated write data and extended load value per size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    wben      = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (size_t'(size))
      SIZE_BYTE: begin
        wben      = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                             : {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        wben      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                             : {16'h0, shifted[15:0]};
      end
      SIZE_WORD: begin
        wben      = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regbus_master.sv
// CPU-side request/response to register-file bus bridge. Accepts one request
// in IDLE, rejects illegal ones without touching the bus, otherwise runs a
// single-cycle ACCESS and holds the response in RESP until it is taken.
module regbus_master
  import regbus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  addr,
  output logic [3:0]  wben,
  output logic        r_wn,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  state_t      state;
  logic        accept;
  logic        req_error;
  size_t       req_size_e;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [5:0]  lat_addr;
  logic [31:0] lat_wdata;

  logic [3:0]  align_wben;
  logic [31:0] align_wdata;
  logic [31:0] load_data;
  logic        in_access;

  assign req_size_e = size_t'(req_size);
  assign accept     = req_valid && req_ready;
  assign in_access  = (state == ST_ACCESS);

  // Request legality check on the live request fields.
  always_comb begin
    req_error = 1'b0;
    if (req_size_e == SIZE_ILLEGAL)                            req_error = 1'b1;
    if (req_size_e == SIZE_HALF && req_addr[0])                req_error = 1'b1;
    if (req_size_e == SIZE_WORD && req_addr[1:0] != 2'b00)     req_error = 1'b1;
    if (req_addr[31:6] != BASE_ADDR[31:6])                     req_error = 1'b1;
    if (req_addr[5:2] > OFF_LAST)                              req_error = 1'b1;
    if (req_we && is_read_only(req_addr[5:2]))                 req_error = 1'b1;
  end

  // Capture the request payload on acceptance.
  // NOTE: payload registers carry no reset; they are only consumed in states
  // that can be reached solely through a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= req_we;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_addr   <= req_addr[5:0];
      lat_wdata  <= req_wdata;
    end
  end

  regbus_lane_align u_lane_align (
    .size       (lat_size),
    .addr_lo    (lat_addr[1:0]),
    .sign_ext   (lat_signed),
    .store_data (lat_wdata),
    .bus_rdata  (rdata),
    .wben       (align_wben),
    .wdata      (align_wdata),
    .load_data  (load_data)
  );

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_error) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lat_we ? 32'h0 : load_data;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Bus drive is gated by the registered ACCESS state, so reset idles it at once.
  assign addr  = in_access ? lat_addr[5:2] : 4'h0;
  assign r_wn  = !(in_access && lat_we);
  assign wben  = (in_access && lat_we) ? align_wben  : 4'h0;
  assign wdata = (in_access && lat_we) ? align_wdata : 32'h0;

endmodule

// File: tb/tb_regbus_master.sv
// Scoreboard bench for regbus_master: stimulus pushes expected responses and
// expected bus cycles; independent monitors pop and compare.
module tb_regbus_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  addr;
  logic [3:0]  wben;
  logic        r_wn;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          rise_cyc;
  } rsp_exp_t;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [3:0]  wben;
    logic        r_wn;
    logic [31:0] wdata;
  } bus_exp_t;

  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];

  regbus_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .addr       (addr),
    .wben       (wben),
    .r_wn       (r_wn),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: tracks the rising cycle of rsp_valid and compares on handshake.
  initial begin : rsp_monitor
    logic     prev;
    int       rise;
    rsp_exp_t e;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (rsp_valid && !prev) rise = cyc;
        prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b expected no response", rsp_rdata, rsp_err);
          end else begin
            e = rsp_q.pop_front();
            check({e.name, "_rdata"}, rsp_rdata, e.rdata);
            check({e.name, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
            check({e.name, "_rsp_cycle"}, rise, e.rise_cyc);
          end
        end
      end
    end
  end

  // Bus monitor: any non-idle bus cycle must match the next expected one.
  initial begin : bus_monitor
    bus_exp_t b;
    forever begin
      @(negedge clk);
      if (reset && (r_wn !== 1'b1 || wben !== 4'h0 || addr !== 4'h0 || wdata !== 32'h0)) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus: got addr=%0h wben=%b r_wn=%0b wdata=0x%08h expected idle bus",
                   addr, wben, r_wn, wdata);
        end else begin
          b = bus_q.pop_front();
          check({b.name, "_addr"}, {28'h0, addr}, {28'h0, b.addr});
          check({b.name, "_wben"}, {28'h0, wben}, {28'h0, b.wben});
          check({b.name, "_r_wn"}, {31'h0, r_wn}, {31'h0, b.r_wn});
          check({b.name, "_wdata"}, wdata, b.wdata);
        end
      end
    end
  end

  // Issue one request and queue its expected response and bus cycle.
  task automatic send(input string name, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic [3:0] exp_wben,
                      input logic [31:0] exp_wdata, output int acc);
    int       n;
    rsp_exp_t r;
    bus_exp_t b;
    n   = 0;
    acc = -1;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got req_ready=0 expected 1 within 50 cycles", name);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = wd;
    rdata      = rd;
    @(posedge clk); #1;
    acc        = cyc;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    r.name     = name;
    r.rdata    = exp_rdata;
    r.err      = exp_err;
    r.rise_cyc = exp_err ? acc : acc + 1;
    rsp_q.push_back(r);
    if (!exp_err && (we || a[5:2] != 4'h0)) begin
      b.name  = name;
      b.addr  = a[5:2];
      b.wben  = exp_wben;
      b.r_wn  = !we;
      b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_rsp_q", rsp_q.size(), 0);
  endtask

  initial begin : stimulus
    int a0, a1, a2;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    rdata      = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_r_wn",      {31'h0, r_wn},      32'h1);
    check("rst_wben",      {28'h0, wben},      32'h0);
    check("rst_addr",      {28'h0, addr},      32'h0);
    check("rst_wdata",     wdata,              32'h0);
    reset = 1'b1;

    //    name         we    size   sgn  addr          wdata         rdata         exp_rdata     err   wben     exp_wdata
    send("st_word",    1'b1, 2'b10, 0, 32'h4000_0018, 32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, a0);
    send("ld_b_sgn",   1'b0, 2'b00, 1, 32'h4000_0003, 32'h0,        32'h8000_0000, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0, a0);
    send("ld_b_uns",   1'b0, 2'b00, 0, 32'h4000_0003, 32'h0,        32'h8000_0000, 32'h0000_0080, 1'b0, 4'b0000, 32'h0, a0);
    send("st_half",    1'b1, 2'b01, 0, 32'h4000_0016, 32'h1234_A5C3, 32'h0,        32'h0,        1'b0, 4'b1100, 32'hA5C3_A5C3, a0);
    send("ld_h_mis",   1'b0, 2'b01, 0, 32'h4000_0011, 32'h0,        32'hFFFF_FFFF, 32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("st_ro_0",    1'b1, 2'b10, 0, 32'h4000_0000, 32'h5555_AAAA, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("ld_hole_d",  1'b0, 2'b10, 0, 32'h4000_0034, 32'h0,        32'h1111_1111, 32'h0,        1'b1, 4'b0000, 32'h0, a1);
    check("err_spacing", a1 - a0, 2);
    send("ld_window",  1'b0, 2'b10, 0, 32'h5000_0000, 32'h0,        32'h2222_2222, 32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("size_ill",   1'b0, 2'b11, 0, 32'h4000_0008, 32'h0,        32'h3333_3333, 32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("st_byte",    1'b1, 2'b00, 0, 32'h4000_0029, 32'h0000_005A, 32'h0,        32'h0,        1'b0, 4'b0010, 32'h5A5A_5A5A, a0);
    send("ld_h_sgn",   1'b0, 2'b01, 1, 32'h4000_0012, 32'h0,        32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0, a1);
    send("ld_word",    1'b0, 2'b10, 0, 32'h4000_0030, 32'h0,        32'h1234_5678, 32'h1234_5678, 1'b0, 4'b0000, 32'h0, a2);
    check("ok_spacing", a2 - a1, 3);
    send("st_w_mis",   1'b1, 2'b10, 0, 32'h4000_0022, 32'hFFFF_0000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("st_ro_b",    1'b1, 2'b10, 0, 32'h4000_002C, 32'h0F0F_0F0F, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0, a0);
    send("ld_b9_uns",  1'b0, 2'b00, 0, 32'h4000_0025, 32'h0,        32'hCAFE_BABE, 32'h0000_00BA, 1'b0, 4'b0000, 32'h0, a0);
    send("ld_b9_sgn",  1'b0, 2'b00, 1, 32'h4000_0025, 32'h0,        32'hCAFE_BABE, 32'hFFFF_FFBA, 1'b0, 4'b0000, 32'h0, a0);
    drain();

    // Response stall: outputs hold, new requests are ignored.
    rsp_ready = 1'b0;
    send("ld_stall",   1'b0, 2'b10, 0, 32'h4000_0018, 32'h0,        32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0, a0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h4000_0018;
    req_wdata = 32'h7777_7777;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rsp_rdata", rsp_rdata,          32'h0BAD_F00D);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset in the middle of a store access.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h4000_0018;
    req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_access_r_wn", {31'h0, r_wn}, 32'h0);
    reset = 1'b0;
    #1;
    check("abort_r_wn",      {31'h0, r_wn},      32'h1);
    check("abort_wben",      {28'h0, wben},      32'h0);
    check("abort_wdata",     wdata,              32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_rsp_rdata", rsp_rdata,          32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("post_abort_req_ready", {31'h0, req_ready}, 32'h1);

    send("st_after",   1'b1, 2'b10, 0, 32'h4000_0028, 32'hCAFE_F00D, 32'h0,        32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D, a0);
    drain();
    repeat (3) @(posedge clk);
    check("bus_q_empty", bus_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
